cpu_sram_bridge: RTL and testbench
==================================

Name: cpu_sram_bridge

Overview:
- Memory-side stage directly downstream of the x86 core. It turns the core's byte-wide request bus (20-bit linear address, 8-bit data, we) into cycles on an external 16-bit asynchronous SRAM with programmable wait states.
- It adds a one-word read buffer, so consecutive byte fetches from the same word complete in one cycle.
- It returns a `cpu_ready` strobe; the core stalls its state machine until `cpu_ready` is seen.

Parameters:
- WAIT_STATES, 1, extra SRAM access cycles beyond the first; legal range 0..7.
- ADDR_W, 20, CPU linear address width; the SRAM word address is ADDR_W-1 bits.

Ports:
- clock  in  1  system clock, 25 MHz; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- cpu_req  in  1  level; request present, held stable until `cpu_ready`.
- cpu_address  in  20  linear byte address.
- cpu_we  in  1  1 = write byte, 0 = read byte.
- cpu_o_data  in  8  write data.
- cpu_i_data  out  8  read data, valid while `cpu_ready`=1 and held until the next completion.
- cpu_ready  out  1  one-cycle completion strobe.
- flush  in  1  invalidate the read buffer (e.g. after external DMA).
- sram_addr  out  19  word address = cpu_address[19:1].
- sram_dq_in  in  16  SRAM read data.
- sram_dq_out  out  16  SRAM write data; the byte is replicated on both lanes.
- sram_dq_oe  out  1  drive the data bus.
- sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  active-low SRAM strobes.

Behaviour:
- Reset (asynchronous, immediate):
  - state=IDLE, buffer valid=0, cpu_ready=0, cpu_i_data=0, sram_dq_oe=0.
  - All sram_*_n=1, sram_addr=0, sram_dq_out=0.
  - Reset mid-access aborts the cycle: strobes deassert in the same instant and no completion strobe is issued.
- Byte lanes: cpu_address[0]=0 selects low byte / lb_n; cpu_address[0]=1 selects high byte / ub_n.
- Reads: enable both lanes and latch the full word.
- Writes: enable only the addressed lane.
- States: IDLE, RD, WR, DONE. A request is sampled only in IDLE.
- IDLE, read hit (cpu_req=1, we=0, valid=1, buffer tag == cpu_address[19:1]):
  - next state DONE; cpu_i_data = selected byte of the buffer.
  - Latency 1 cycle from request sample to `cpu_ready`.
- IDLE, read miss:
  - Go to RD; load the wait counter with WAIT_STATES.
  - sram_oe_n=0, ub_n=lb_n=0 and sram_addr are driven from the cycle after sampling.
- RD:
  - The counter decrements each cycle.
  - When the counter is 0: latch sram_dq_in into the buffer, set tag and valid=1, drive the selected byte onto cpu_i_data, go to DONE.
  - Read miss latency = WAIT_STATES+2 cycles.
- IDLE, write (cpu_req=1, we=1):
  - Go to WR; counter=WAIT_STATES.
  - sram_dq_oe=1, sram_we_n=0, addressed lane strobe=0.
  - sram_dq_out = {cpu_o_data, cpu_o_data}.
- WR:
  - Hold address and data stable; the counter decrements.
  - When the counter is 0: go to DONE.
  - The buffer is write-through. If the buffer is valid and the tag matches, the addressed byte in the buffer is updated with cpu_o_data.
- DONE:
  - cpu_ready=1 for exactly one cycle; all SRAM strobes deasserted (this is the recovery cycle); sram_dq_oe=0.
  - Next state IDLE.
  - Write latency = WAIT_STATES+2 cycles.
- Back-to-back requests:
  - The requester must change or deassert cpu_req in the cycle after `cpu_ready`.
  - A request still present in IDLE is treated as new.
  - Minimum spacing between `cpu_ready` strobes is 2 cycles.
- flush:
  - Clears valid on the next edge in any state.
  - If flush coincides with the RD completion edge, data is still returned to the CPU but valid stays 0 (flush wins).
  - If flush coincides with an IDLE hit check, the access is treated as a miss.
- Request attributes: cpu_address, cpu_we and cpu_o_data are registered at IDLE sample. Later changes during RD/WR are ignored.
- SRAM bus rules:
  - sram_oe_n and sram_we_n are never both 0.
  - sram_dq_oe=1 only in WR.
- Wait counter: 3 bits; no wrap. The RD/WR exit condition is counter==0.

Test Plan:
- Cold read, WAIT_STATES=1:
  - Stimulus: reset, then read 0x12345 with SRAM word 0x091A2 = 0xBEEF.
  - Required: oe_n low 2 cycles; `cpu_ready` on cycle 3; cpu_i_data=0xBE.
- Buffer hit: immediately read 0x12344 → `cpu_ready` after 1 cycle, cpu_i_data=0xEF, sram_oe_n stays 1.
- Write-through:
  - Stimulus: write 0x5A to 0x12344.
  - Required: we_n low 2 cycles, lb_n=0, ub_n=1, dq_out=0x5A5A, oe_n=1 throughout.
  - Follow-up: read 0x12344 hits with 0x5A.
- Flush:
  - Stimulus: assert flush for one cycle, then read 0x12345.
  - Required: full miss cycle (oe_n asserted); flush coincident with an RD completion still returns data, and the next same-word read misses.
- Reset mid-access: assert reset during RD → all strobes 1 immediately, no `cpu_ready`, subsequent read of the same word misses.
- Sweep WAIT_STATES=0 and 7: read latency 2 / 9 cycles, write latency 2 / 9 cycles; `cpu_ready` pulse width always 1.

Source files
------------

// File: rtl/cpu_sram_bridge.sv
// cpu_sram_bridge: byte-wide CPU bus to 16-bit async SRAM with wait states and a one-word read buffer.
module cpu_sram_bridge #(
    parameter int WAIT_STATES = 1,
    parameter int ADDR_W      = 20
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_we,
    input  logic [7:0]        cpu_o_data,
    output logic [7:0]        cpu_i_data,
    output logic              cpu_ready,
    input  logic              flush,
    output logic [ADDR_W-2:0] sram_addr,
    input  logic [15:0]       sram_dq_in,
    output logic [15:0]       sram_dq_out,
    output logic              sram_dq_oe,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              sram_ub_n,
    output logic              sram_lb_n
);
    typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

    localparam logic [2:0] WS = 3'(WAIT_STATES);

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_r;
    logic [7:0]        data_r;
    logic [2:0]        cnt;
    logic [15:0]       buf_data;
    logic [ADDR_W-2:0] buf_tag;
    logic              buf_valid;
    logic [7:0]        rdata;
    logic              hit;
    logic              tag_match;

    // a flush in the same cycle as the hit check forces a miss
    assign hit       = cpu_req && !cpu_we && buf_valid && !flush && buf_tag == cpu_address[ADDR_W-1:1];
    assign tag_match = buf_valid && buf_tag == addr_r[ADDR_W-1:1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // strobes decode straight from state so reset releases the bus immediately
    always_comb begin
        state_nx    = state;
        cpu_ready   = 1'b0;
        sram_oe_n   = 1'b1;
        sram_we_n   = 1'b1;
        sram_ub_n   = 1'b1;
        sram_lb_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = 16'h0000;
        unique case (state)
            IDLE: state_nx = !cpu_req ? IDLE : cpu_we ? WR : hit ? DONE : RD;
            RD: begin
                state_nx  = (cnt == 3'd0) ? DONE : RD;
                sram_oe_n = 1'b0;
                sram_ub_n = 1'b0;
                sram_lb_n = 1'b0;
            end
            WR: begin
                state_nx    = (cnt == 3'd0) ? DONE : WR;
                sram_we_n   = 1'b0;
                sram_ub_n   = !addr_r[0];
                sram_lb_n   = addr_r[0];
                sram_dq_oe  = 1'b1;
                sram_dq_out = {data_r, data_r};
            end
            default: begin
                state_nx  = IDLE;
                cpu_ready = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_r    <= '0;
            data_r    <= 8'h00;
            cnt       <= 3'd0;
            buf_data  <= 16'h0000;
            buf_tag   <= '0;
            buf_valid <= 1'b0;
            rdata     <= 8'h00;
        end else begin
            if (state == IDLE && cpu_req) begin
                addr_r <= cpu_address;
                data_r <= cpu_o_data;
                cnt    <= WS;
                if (hit) rdata <= cpu_address[0] ? buf_data[15:8] : buf_data[7:0];
            end else if ((state == RD || state == WR) && cnt != 3'd0) begin
                cnt <= cnt - 3'd1;
            end
            if (state == RD && cnt == 3'd0) begin
                buf_data  <= sram_dq_in;
                buf_tag   <= addr_r[ADDR_W-1:1];
                buf_valid <= 1'b1;
                rdata     <= addr_r[0] ? sram_dq_in[15:8] : sram_dq_in[7:0];
            end
            if (state == WR && cnt == 3'd0 && tag_match) begin
                if (addr_r[0]) buf_data[15:8] <= data_r;
                else           buf_data[7:0]  <= data_r;
            end
            if (flush) buf_valid <= 1'b0;
        end
    end

    assign sram_addr  = addr_r[ADDR_W-1:1];
    assign cpu_i_data = rdata;
endmodule

// File: tb/tb_cpu_sram_bridge.sv
// tb_cpu_sram_bridge: directed checks on three bridges built with WAIT_STATES = 1, 0 and 7.
module tb_cpu_sram_bridge;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic [19:0] addr  = 20'h0;
    logic        we    = 1'b0;
    logic [7:0]  wdata = 8'h00;
    logic [15:0] dq_in = 16'h0000;
    logic        req    [3];
    logic [7:0]  idata  [3];
    logic        ready  [3];
    logic [18:0] saddr  [3];
    logic [15:0] dq_out [3];
    logic        dq_oe  [3];
    logic        oe_n   [3];
    logic        we_n   [3];
    logic        ub_n   [3];
    logic        lb_n   [3];

    int n_checks = 0;
    int n_fail   = 0;
    int lat, oe_cnt, we_cnt, bus_bad, ready_cnt;
    logic lb_seen, ub_seen, oe_drv, ready_after;
    logic [15:0] dq_seen;
    logic [7:0]  rd_seen;

    always #5 clock = ~clock;

    // index 0: WAIT_STATES=1, index 1: WAIT_STATES=0, index 2: WAIT_STATES=7
    for (genvar i = 0; i < 3; i++) begin : g_dut
        cpu_sram_bridge #(.WAIT_STATES(i == 0 ? 1 : i == 1 ? 0 : 7), .ADDR_W(20)) u_dut (
            .clock(clock), .reset(reset), .cpu_req(req[i]), .cpu_address(addr), .cpu_we(we),
            .cpu_o_data(wdata), .cpu_i_data(idata[i]), .cpu_ready(ready[i]), .flush(flush),
            .sram_addr(saddr[i]), .sram_dq_in(dq_in), .sram_dq_out(dq_out[i]), .sram_dq_oe(dq_oe[i]),
            .sram_oe_n(oe_n[i]), .sram_we_n(we_n[i]), .sram_ub_n(ub_n[i]), .sram_lb_n(lb_n[i])
        );
    end

    task automatic xfer(input int s, input logic [19:0] a, input logic w, input logic [7:0] d);
        addr = a; we = w; wdata = d; req[s] = 1'b1;
        lat = -1; oe_cnt = 0; we_cnt = 0; bus_bad = 0;
        lb_seen = 1'b1; ub_seen = 1'b1; oe_drv = 1'b0; dq_seen = 16'h0; rd_seen = 8'h00;
        for (int c = 1; c <= 20 && lat < 0; c++) begin
            @(posedge clock); #1;
            if (!oe_n[s]) oe_cnt++;
            if (!we_n[s]) begin we_cnt++; lb_seen = lb_n[s]; ub_seen = ub_n[s]; dq_seen = dq_out[s]; oe_drv = dq_oe[s]; end
            if ((!oe_n[s] && !we_n[s]) || (dq_oe[s] && we_n[s])) bus_bad++;
            if (ready[s]) begin lat = c; rd_seen = idata[s]; end
        end
        req[s] = 1'b0;
        @(posedge clock); #1;
        ready_after = ready[s];
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (ready[0] !== 1'b0) begin n_fail++; $display("FAIL reset_ready got %b expected 0", ready[0]); end
        n_checks++; if (idata[0] !== 8'h00) begin n_fail++; $display("FAIL reset_idata got %h expected 00", idata[0]); end
        n_checks++; if ({oe_n[0], we_n[0], ub_n[0], lb_n[0]} !== 4'hF) begin n_fail++; $display("FAIL reset_strobes got %b expected 1111", {oe_n[0], we_n[0], ub_n[0], lb_n[0]}); end
        n_checks++; if ({dq_oe[0], saddr[0], dq_out[0]} !== 36'h0) begin n_fail++; $display("FAIL reset_bus got %h expected 0", {dq_oe[0], saddr[0], dq_out[0]}); end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_cold_read;
        dq_in = 16'hBEEF;
        xfer(0, 20'h12345, 1'b0, 8'h00);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL cold_latency got %0d expected 3", lat); end
        n_checks++; if (oe_cnt !== 2) begin n_fail++; $display("FAIL cold_oe_cycles got %0d expected 2", oe_cnt); end
        n_checks++; if (rd_seen !== 8'hBE) begin n_fail++; $display("FAIL cold_data got %h expected be", rd_seen); end
        n_checks++; if (ready_after !== 1'b0) begin n_fail++; $display("FAIL cold_ready_width got %b expected 0", ready_after); end
        n_checks++; if (idata[0] !== 8'hBE) begin n_fail++; $display("FAIL cold_data_hold got %h expected be", idata[0]); end
    endtask

    task automatic test_hit;
        dq_in = 16'h0000;
        xfer(0, 20'h12344, 1'b0, 8'h00);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL hit_latency got %0d expected 1", lat); end
        n_checks++; if (oe_cnt !== 0) begin n_fail++; $display("FAIL hit_oe_cycles got %0d expected 0", oe_cnt); end
        n_checks++; if (rd_seen !== 8'hEF) begin n_fail++; $display("FAIL hit_data got %h expected ef", rd_seen); end
    endtask

    task automatic test_write_through;
        xfer(0, 20'h12344, 1'b1, 8'h5A);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL wr_latency got %0d expected 3", lat); end
        n_checks++; if (we_cnt !== 2) begin n_fail++; $display("FAIL wr_we_cycles got %0d expected 2", we_cnt); end
        n_checks++; if (oe_cnt !== 0) begin n_fail++; $display("FAIL wr_oe_cycles got %0d expected 0", oe_cnt); end
        n_checks++; if ({lb_seen, ub_seen, oe_drv} !== 3'b011) begin n_fail++; $display("FAIL wr_lanes got lb/ub/oe %b expected 011", {lb_seen, ub_seen, oe_drv}); end
        n_checks++; if (dq_seen !== 16'h5A5A) begin n_fail++; $display("FAIL wr_dq got %h expected 5a5a", dq_seen); end
        n_checks++; if (bus_bad !== 0) begin n_fail++; $display("FAIL wr_bus_rules got %0d expected 0", bus_bad); end
        xfer(0, 20'h12344, 1'b0, 8'h00);
        n_checks++; if ({lat, oe_cnt} !== {32'd1, 32'd0}) begin n_fail++; $display("FAIL wr_hit lat/oe got %0d/%0d expected 1/0", lat, oe_cnt); end
        n_checks++; if (rd_seen !== 8'h5A) begin n_fail++; $display("FAIL wr_hit_data got %h expected 5a", rd_seen); end
    endtask

    task automatic test_flush;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0;
        dq_in = 16'hBE5A;
        xfer(0, 20'h12345, 1'b0, 8'h00);
        n_checks++; if ({lat, oe_cnt} !== {32'd3, 32'd2}) begin n_fail++; $display("FAIL flush_miss lat/oe got %0d/%0d expected 3/2", lat, oe_cnt); end
        n_checks++; if (rd_seen !== 8'hBE) begin n_fail++; $display("FAIL flush_miss_data got %h expected be", rd_seen); end
        dq_in = 16'h1234;
        addr = 20'h20001; we = 1'b0; req[0] = 1'b1;
        @(posedge clock); #1;
        @(posedge clock); #1;
        flush = 1'b1;
        @(posedge clock); #1;
        flush = 1'b0; req[0] = 1'b0;
        n_checks++; if (ready[0] !== 1'b1) begin n_fail++; $display("FAIL flush_rd_ready got %b expected 1", ready[0]); end
        n_checks++; if (idata[0] !== 8'h12) begin n_fail++; $display("FAIL flush_rd_data got %h expected 12", idata[0]); end
        @(posedge clock); #1;
        xfer(0, 20'h20000, 1'b0, 8'h00);
        n_checks++; if ({lat, oe_cnt} !== {32'd3, 32'd2}) begin n_fail++; $display("FAIL flush_rd_next lat/oe got %0d/%0d expected 3/2", lat, oe_cnt); end
        n_checks++; if (rd_seen !== 8'h34) begin n_fail++; $display("FAIL flush_rd_next_data got %h expected 34", rd_seen); end
        flush = 1'b1;
        xfer(0, 20'h20000, 1'b0, 8'h00);
        flush = 1'b0;
        n_checks++; if (oe_cnt !== 2) begin n_fail++; $display("FAIL flush_hit_check oe got %0d expected 2", oe_cnt); end
    endtask

    task automatic test_reset_mid_access;
        dq_in = 16'hBE5A;
        xfer(0, 20'h12345, 1'b0, 8'h00);
        xfer(0, 20'h12345, 1'b0, 8'h00);
        n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL pre_reset_hit got %0d expected 1", lat); end
        addr = 20'h00100; we = 1'b0; req[0] = 1'b1;
        @(posedge clock); #1;
        n_checks++; if (oe_n[0] !== 1'b0) begin n_fail++; $display("FAIL mid_rd_oe got %b expected 0", oe_n[0]); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if ({oe_n[0], we_n[0], ub_n[0], lb_n[0]} !== 4'hF) begin n_fail++; $display("FAIL mid_reset_strobes got %b expected 1111", {oe_n[0], we_n[0], ub_n[0], lb_n[0]}); end
        n_checks++; if ({dq_oe[0], saddr[0]} !== 20'h0) begin n_fail++; $display("FAIL mid_reset_bus got %h expected 0", {dq_oe[0], saddr[0]}); end
        req[0] = 1'b0;
        ready_cnt = 0;
        @(posedge clock); #1;
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (ready[0]) ready_cnt++;
            @(posedge clock); #1;
        end
        n_checks++; if (ready_cnt !== 0) begin n_fail++; $display("FAIL mid_reset_no_ready got %0d expected 0", ready_cnt); end
        xfer(0, 20'h12345, 1'b0, 8'h00);
        n_checks++; if ({lat, oe_cnt} !== {32'd3, 32'd2}) begin n_fail++; $display("FAIL post_reset_miss lat/oe got %0d/%0d expected 3/2", lat, oe_cnt); end
        n_checks++; if (rd_seen !== 8'hBE) begin n_fail++; $display("FAIL post_reset_data got %h expected be", rd_seen); end
    endtask

    task automatic test_wait_sweep;
        dq_in = 16'hCAFE;
        xfer(1, 20'h00201, 1'b0, 8'h00);
        n_checks++; if ({lat, oe_cnt} !== {32'd2, 32'd1}) begin n_fail++; $display("FAIL ws0_read lat/oe got %0d/%0d expected 2/1", lat, oe_cnt); end
        n_checks++; if ({rd_seen, ready_after} !== {8'hCA, 1'b0}) begin n_fail++; $display("FAIL ws0_read data/after got %h/%b expected ca/0", rd_seen, ready_after); end
        xfer(1, 20'h00201, 1'b1, 8'h77);
        n_checks++; if ({lat, we_cnt} !== {32'd2, 32'd1}) begin n_fail++; $display("FAIL ws0_write lat/we got %0d/%0d expected 2/1", lat, we_cnt); end
        n_checks++; if ({lb_seen, ub_seen, dq_seen} !== {2'b10, 16'h7777}) begin n_fail++; $display("FAIL ws0_write lanes got %b/%b/%h expected 1/0/7777", lb_seen, ub_seen, dq_seen); end
        xfer(2, 20'h00200, 1'b0, 8'h00);
        n_checks++; if ({lat, oe_cnt} !== {32'd9, 32'd8}) begin n_fail++; $display("FAIL ws7_read lat/oe got %0d/%0d expected 9/8", lat, oe_cnt); end
        n_checks++; if ({rd_seen, ready_after} !== {8'hFE, 1'b0}) begin n_fail++; $display("FAIL ws7_read data/after got %h/%b expected fe/0", rd_seen, ready_after); end
        xfer(2, 20'h00200, 1'b1, 8'h33);
        n_checks++; if ({lat, we_cnt} !== {32'd9, 32'd8}) begin n_fail++; $display("FAIL ws7_write lat/we got %0d/%0d expected 9/8", lat, we_cnt); end
        n_checks++; if ({lb_seen, ub_seen, dq_seen, ready_after} !== {2'b01, 16'h3333, 1'b0}) begin n_fail++; $display("FAIL ws7_write lanes got %b/%b/%h/%b expected 0/1/3333/0", lb_seen, ub_seen, dq_seen, ready_after); end
        xfer(2, 20'h00200, 1'b0, 8'h00);
        n_checks++; if ({lat, rd_seen} !== {32'd1, 8'h33}) begin n_fail++; $display("FAIL ws7_hit lat/data got %0d/%h expected 1/33", lat, rd_seen); end
    endtask

    initial begin
        foreach (req[k]) req[k] = 1'b0;
        test_reset;
        test_cold_read;
        test_hit;
        test_write_through;
        test_flush;
        test_reset_mid_access;
        test_wait_sweep;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
